cnn_stage_sequencer: RTL and testbench
======================================

// Module: cnn_stage_sequencer
// PURPOSE
//  Runs the CNN layer pipeline (quantize, conv, pool, FC) one stage at a time.
//  Sequence per stage: power up, wait settle, enable clock, pulse start, wait done, gate clock.
//  Stage k-1 is powered off once stage k completes; stage k has consumed k-1's output by then.
//  Sits between the host start/done handshake and the per-layer enable/start/done wires.
// PARAMETERS
//  NUM_STAGES      4    number of sequenced layer stages (>=2)
//  SETTLE_CYCLES   4    cycles from pwr_en rise to clk_en rise (>=1)
//  TIMEOUT_CYCLES  255  max cycles in WAIT_DONE before error (>=1)
//  RETAIN_LAST     1    1: last stage stays powered after done (results readable); 0: all off
// PORTS
//  clk           in   1             system clock
//  rst_n         in   1             asynchronous active-low reset
//  start         in   1             host request; sampled only in IDLE/ERROR
//  abort         in   1             host cancel; highest priority in any state
//  stage_done    in   NUM_STAGES    per-stage completion; level or pulse
//  stage_pwr_en  out  NUM_STAGES    per-stage power enable
//  stage_clk_en  out  NUM_STAGES    per-stage clock enable (feeds glitch-free gate)
//  stage_start   out  NUM_STAGES    one-cycle start pulse to the active stage
//  cur_stage     out  $clog2(NUM_STAGES)  index of active stage
//  busy          out  1             high from start accept until done/error/abort
//  done          out  1             one-cycle pulse on successful completion
//  error         out  1             sticky timeout flag
//  err_stage     out  $clog2(NUM_STAGES)  stage that timed out; valid while error=1
// BEHAVIOUR
//  Reset: every output is 0; state = IDLE; counters cleared.
//  All outputs are registered. Transitions below happen on the sampling edge.
//  IDLE: start=1 -> cur_stage=0, pwr_en[0]=1, busy=1, timer=0, go to SETTLE.
//    If RETAIN_LAST=1, the retained last-stage power drops on this same edge.
//  SETTLE: timer counts up. At timer==SETTLE_CYCLES-1 -> clk_en[cur]=1, stage_start[cur]=1, go to RUN.
//  RUN (1 cycle): stage_start returns to 0; timer=0; go to WAIT_DONE.
//  WAIT_DONE: only stage_done[cur_stage] is sampled; other bits are ignored.
//    done bit seen -> clk_en[cur]=0.
//      Not last stage: pwr_en[cur+1]=1 and pwr_en[cur-1]=0 (if cur>0);
//        cur_stage increments; timer=0; go to SETTLE.
//      Last stage: go to FINISH.
//    If done coincides with timer==TIMEOUT_CYCLES-1, done wins.
//    Timeout with no done -> all clk_en=0, all pwr_en=0, error=1, err_stage=cur,
//      busy=0, go to ERROR.
//  FINISH (1 cycle): done=1, busy=0, go to IDLE.
//    Power drops for every stage except the last when RETAIN_LAST=1.
//  ERROR: outputs held. start=1 -> clear error, then behave as IDLE+start on the same edge.
//  abort=1 in any state except IDLE:
//    next edge all enables=0, stage_start=0, busy=0, error=0; go to IDLE; no done pulse.
//    abort overrides a simultaneous start or stage_done.
//  Invariants:
//    at most two stages powered at once;
//    clk_en[k] only while pwr_en[k];
//    clk_en[k] rises no sooner than SETTLE_CYCLES after pwr_en[k].
//  Latency, no stalls: done is seen NUM_STAGES*(SETTLE_CYCLES+2)+1 edges after start is sampled.
//  start while busy is ignored. No queuing.
//  Counter width: $clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES)+1). The counter saturates and never wraps.
// STRUCTURE
//  cnn_ctrl_pkg holds:
//    state encoding (IDLE, SETTLE, RUN, WAIT_DONE, FINISH, ERROR);
//    default stage-count and timing localparams shared with the datapath.
//  Sub-module cnn_stage_timer: clear/enable up-counter that flags a terminal count.
//    Used for both the settle wait and the timeout.
//  Top level: FSM plus a one-hot stage decoder for the pwr/clk/start vectors.
// TESTING
//  1. Nominal run, NUM_STAGES=4, SETTLE=2; each stage_done pulses 1 cycle after its start.
//     -> done pulses exactly once, 17 edges after start.
//     -> stage_start order 0,1,2,3; popcount(stage_pwr_en)<=2 every cycle.
//  2. Stage 2 never asserts done, TIMEOUT=8.
//     -> after 8 WAIT_DONE cycles: error=1, err_stage=2, all enables=0, busy=0.
//     -> a new start clears error and restarts at stage 0.
//  3. abort in stage 1 SETTLE -> next cycle all enables 0, busy=0, no done.
//     -> the following start runs cleanly to done.
//  4. stage_done[3] held high throughout while stage 0 is active.
//     -> ignored: stage 0 is not advanced until stage_done[0].
//  5. start pulsed again mid-run -> ignored; exactly one done pulse results.
//  6. rst_n asserted during WAIT_DONE of stage 1 -> all outputs 0 immediately, asynchronously.
//     -> after release, state is IDLE.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared state encoding and default stage/timing parameters for the CNN stage sequencer.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  localparam int unsigned DEF_NUM_STAGES     = 4;
  localparam int unsigned DEF_SETTLE_CYCLES  = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam bit          DEF_RETAIN_LAST    = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_stage_timer.sv
// Clear/enable up-counter with a terminal-count flag; shared by the settle wait and the done timeout.
module cnn_stage_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] tc_val_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at all-ones so a long stall can never wrap back into a false terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/cnn_stage_sequencer.sv
// Sequences CNN layer stages one at a time: power up, settle, clock, start, wait done, gate clock.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for host start; last stage may still be retained
// SETTLE    | current stage powered, waiting for supply to settle
// RUN       | one cycle with stage_start high
// WAIT_DONE | waiting for stage_done of current stage, timeout armed
// FINISH    | one cycle before the done pulse and power-down
// ERROR     | timeout seen; outputs held until start or abort
module cnn_stage_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter bit          RETAIN_LAST    = DEF_RETAIN_LAST,
  localparam int unsigned SW = $clog2(NUM_STAGES)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NUM_STAGES-1:0] stage_done_i,
  output logic [NUM_STAGES-1:0] stage_pwr_en_o,
  output logic [NUM_STAGES-1:0] stage_clk_en_o,
  output logic [NUM_STAGES-1:0] stage_start_o,
  output logic [SW-1:0]         cur_stage_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [SW-1:0]         err_stage_o
);

  localparam int unsigned CW = $clog2(max_u(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] SETTLE_TC  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_OH = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] LAST_OH  = FIRST_OH << (NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [SW-1:0]         cur_q, cur_d;
  logic [NUM_STAGES-1:0] pwr_q, pwr_d, clk_q, clk_d, start_q, start_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [SW-1:0]         err_stage_q, err_stage_d;

  logic                  tmr_clr, tmr_en, tmr_tc;
  logic [CW-1:0]         tmr_tc_val;
  logic [NUM_STAGES-1:0] cur_oh, nxt_oh, prv_oh;
  logic                  is_last;

  // One-hot decode of the active stage and its neighbours; prv_oh is naturally 0 for stage 0.
  assign cur_oh  = FIRST_OH << cur_q;
  assign nxt_oh  = cur_oh << 1;
  assign prv_oh  = cur_oh >> 1;
  assign is_last = (cur_q == SW'(NUM_STAGES - 1));

  assign tmr_en     = (state_q == ST_SETTLE) || (state_q == ST_WAIT_DONE);
  assign tmr_tc_val = (state_q == ST_WAIT_DONE) ? TIMEOUT_TC : SETTLE_TC;

  cnn_stage_timer #(.CW(CW)) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pwr_d       = pwr_q;
    clk_d       = clk_q;
    start_d     = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_stage_d = err_stage_q;
    tmr_clr     = 1'b0;

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      pwr_d       = '0;
      clk_d       = '0;
      busy_d      = 1'b0;
      error_d     = 1'b0;
      err_stage_d = '0;
      tmr_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start_i) begin
            state_d     = ST_SETTLE;
            cur_d       = '0;
            pwr_d       = FIRST_OH;
            clk_d       = '0;
            busy_d      = 1'b1;
            error_d     = 1'b0;
            err_stage_d = '0;
            tmr_clr     = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_tc) begin
            clk_d   = clk_q | cur_oh;
            start_d = cur_oh;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          tmr_clr = 1'b1;
          state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Done wins over a coincident timeout.
          if (stage_done_i[cur_q]) begin
            clk_d   = clk_q & ~cur_oh;
            tmr_clr = 1'b1;
            if (is_last) begin
              state_d = ST_FINISH;
            end else begin
              pwr_d   = (pwr_q | nxt_oh) & ~prv_oh;
              cur_d   = cur_q + SW'(1);
              state_d = ST_SETTLE;
            end
          end else if (tmr_tc) begin
            clk_d       = '0;
            pwr_d       = '0;
            error_d     = 1'b1;
            err_stage_d = cur_q;
            busy_d      = 1'b0;
            state_d     = ST_ERROR;
          end
        end
        ST_FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pwr_d   = RETAIN_LAST ? (pwr_q & LAST_OH) : '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      pwr_q       <= '0;
      clk_q       <= '0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pwr_q       <= pwr_d;
      clk_q       <= clk_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign stage_pwr_en_o = pwr_q;
  assign stage_clk_en_o = clk_q;
  assign stage_start_o  = start_q;
  assign cur_stage_o    = cur_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign err_stage_o    = err_stage_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Self-checking bench for cnn_stage_sequencer: table of whole-run scenarios plus hand-written corner sequences.
module tb_cnn_stage_sequencer;

  localparam int NS     = 4;
  localparam int SETTLE = 2;
  localparam int TMO    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_done = '0;
  logic [NS-1:0] pwr_en, clk_en, stage_start;
  logic [1:0]    cur_stage, err_stage;
  logic          busy, done_o, error_o;

  always #5 clk = ~clk;

  cnn_stage_sequencer #(
    .NUM_STAGES     (NS),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .RETAIN_LAST    (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .stage_done_i   (stage_done),
    .stage_pwr_en_o (pwr_en),
    .stage_clk_en_o (clk_en),
    .stage_start_o  (stage_start),
    .cur_stage_o    (cur_stage),
    .busy_o         (busy),
    .done_o         (done_o),
    .error_o        (error_o),
    .err_stage_o    (err_stage)
  );

  typedef struct {
    int         stuck;
    bit         exp_done;
    bit         exp_err;
    int         exp_err_stage;
    int         exp_lat;
    logic [3:0] exp_pwr;
  } row_t;

  row_t          rows[6];
  int            expq[$];
  int            n_cmp = 0, n_fail = 0;
  int            cyc = 0, t0 = 0, done_cnt = 0;
  logic [NS-1:0] pend = '0, held = '0, stuck_mask = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One clock: sample after the edge, check invariants, score stage_start, drive the layer model.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    chk("pwr_popcount_le2", {31'd0, ($countones(pwr_en) > 2)}, 32'd0);
    chk("clk_en_without_pwr", {28'd0, clk_en & ~pwr_en}, 32'd0);
    if (done_o) done_cnt++;
    if (stage_start != '0) begin
      if (expq.size() == 0) begin
        chk("unexpected_stage_start", {28'd0, stage_start}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("stage_start_order", {28'd0, stage_start}, 32'd1 << e);
        chk("cur_stage_at_start", {30'd0, cur_stage}, e);
      end
    end
    stage_done = pend | held;
    pend       = stage_start & ~stuck_mask;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pwr"}, {28'd0, pwr_en}, 0);
    chk({tag, "_clk"}, {28'd0, clk_en}, 0);
    chk({tag, "_start"}, {28'd0, stage_start}, 0);
    chk({tag, "_cur"}, {30'd0, cur_stage}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done_o}, 0);
    chk({tag, "_error"}, {31'd0, error_o}, 0);
    chk({tag, "_err_stage"}, {30'd0, err_stage}, 0);
  endtask

  task automatic kick(input int nexp);
    for (int i = 0; i < nexp; i++) expq.push_back(i);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("accept_busy", {31'd0, busy}, 1);
    chk("accept_pwr", {28'd0, pwr_en}, 4'b0001);
    chk("accept_error", {31'd0, error_o}, 0);
    chk("accept_cur", {30'd0, cur_stage}, 0);
  endtask

  task automatic wait_end(output int lat, output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    lat      = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_o || error_o) begin
        got_done = done_o;
        got_err  = error_o;
        lat      = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_end: got no done/error, want one within 200 cycles");
    end
  endtask

  initial begin
    int  lat;
    bit  gd, ge, found;

    rows[0] = '{-1, 1'b1, 1'b0, 0, 17, 4'b1000};
    rows[1] = '{ 2, 1'b0, 1'b1, 2, 19, 4'b0000};
    rows[2] = '{-1, 1'b1, 1'b0, 0, 17, 4'b1000};
    rows[3] = '{ 0, 1'b0, 1'b1, 0, 11, 4'b0000};
    rows[4] = '{ 3, 1'b0, 1'b1, 3, 23, 4'b0000};
    rows[5] = '{-1, 1'b1, 1'b0, 0, 17, 4'b1000};

    // Reset state
    repeat (3) tick();
    chk_zero("in_reset");
    rst_n = 1'b1;
    repeat (2) tick();
    chk_zero("idle_after_reset");

    // Whole-run scenarios
    for (int r = 0; r < 6; r++) begin
      stuck_mask = (rows[r].stuck < 0) ? 4'b0000 : (4'b0001 << rows[r].stuck);
      kick((rows[r].stuck < 0) ? NS : rows[r].stuck + 1);
      wait_end(lat, gd, ge);
      chk($sformatf("row%0d_done", r), {31'd0, gd}, {31'd0, rows[r].exp_done});
      chk($sformatf("row%0d_error", r), {31'd0, ge}, {31'd0, rows[r].exp_err});
      chk($sformatf("row%0d_latency", r), lat, rows[r].exp_lat);
      chk($sformatf("row%0d_busy", r), {31'd0, busy}, 0);
      chk($sformatf("row%0d_pwr", r), {28'd0, pwr_en}, {28'd0, rows[r].exp_pwr});
      chk($sformatf("row%0d_clk", r), {28'd0, clk_en}, 0);
      chk($sformatf("row%0d_err_stage", r), {30'd0, err_stage}, rows[r].exp_err_stage);
      chk($sformatf("row%0d_queue_left", r), expq.size(), 0);
      tick();
      chk($sformatf("row%0d_done_after", r), {31'd0, done_o}, 0);
      chk($sformatf("row%0d_error_after", r), {31'd0, error_o}, {31'd0, rows[r].exp_err});
      expq.delete();
    end
    stuck_mask = '0;

    // Abort during stage 1 SETTLE
    done_cnt = 0;
    kick(NS);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (cur_stage == 2'd1) found = 1'b1;
    end
    chk("abort_reach_stage1", {31'd0, found}, 1);
    chk("abort_pre_pwr", {28'd0, pwr_en}, 4'b0011);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pwr", {28'd0, pwr_en}, 0);
    chk("abort_clk", {28'd0, clk_en}, 0);
    chk("abort_start", {28'd0, stage_start}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_queue_left", expq.size(), 3);
    expq.delete();
    repeat (30) tick();
    chk("abort_no_done", done_cnt, 0);
    kick(NS);
    wait_end(lat, gd, ge);
    chk("post_abort_done", {31'd0, gd}, 1);
    chk("post_abort_latency", lat, 17);

    // stage_done[3] held while stage 0 waits
    repeat (2) tick();
    held       = 4'b1000;
    stuck_mask = 4'b0001;
    kick(NS);
    repeat (8) tick();
    chk("held3_cur", {30'd0, cur_stage}, 0);
    chk("held3_clk", {28'd0, clk_en}, 4'b0001);
    chk("held3_error", {31'd0, error_o}, 0);
    held       = 4'b0001;
    stuck_mask = 4'b0000;
    tick();
    held = 4'b0000;
    tick();
    chk("held3_advance_cur", {30'd0, cur_stage}, 1);
    chk("held3_advance_pwr", {28'd0, pwr_en}, 4'b0011);
    wait_end(lat, gd, ge);
    chk("held3_done", {31'd0, gd}, 1);
    chk("held3_latency", lat, 23);
    chk("held3_queue_left", expq.size(), 0);
    expq.delete();

    // start pulsed again mid-run
    repeat (2) tick();
    done_cnt = 0;
    kick(NS);
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end(lat, gd, ge);
    chk("midstart_done", {31'd0, gd}, 1);
    chk("midstart_latency", lat, 17);
    repeat (5) tick();
    chk("midstart_done_count", done_cnt, 1);
    chk("midstart_queue_left", expq.size(), 0);
    expq.delete();

    // Asynchronous reset during stage 1 WAIT_DONE
    kick(NS);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (stage_start == 4'b0010) found = 1'b1;
    end
    chk("rst_reach_stage1", {31'd0, found}, 1);
    tick();
    chk("rst_pre_clk", {28'd0, clk_en}, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    stage_done = '0;
    pend       = '0;
    expq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_zero("rst_released_idle");
    kick(NS);
    wait_end(lat, gd, ge);
    chk("post_rst_done", {31'd0, gd}, 1);
    chk("post_rst_latency", lat, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
